// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, and the bubble/hold to IF/ID.
// Optional bubble counter enabled by defining IFU_PERF_CNT_EN.
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | request pc_q from imem, waiting for imem_ready_i
// WAIT  | request accepted, waiting for imem_rvalid_i (drop_q squashes it)
// FULL  | buffer holds a valid instruction presented to IF/ID
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef IFU_PERF_CNT_EN
  ,
  parameter int          CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic                 imem_req_o,
  output logic [31:0]          imem_addr_o,
  input  logic                 imem_ready_i,
  input  logic                 imem_rvalid_i,
  input  logic [31:0]          imem_rdata_i,
  output logic [31:0]          pc_o,
  output logic [31:0]          instr_o,
  output logic                 ifid_hold_o
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] redirect_pc;

  assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      drop_q     <= 1'b0;
      buf_q      <= NOP_INSTR;
      buf_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    instr_o     = NOP_INSTR;
    pc_o        = '0;
    ifid_hold_o = stall_i & ~redirect_i;

    case (state_q)
      S_REQ: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          pc_d = redirect_pc;
          // The accepted request still carries the stale pc_q; squash its response.
          if (imem_ready_i) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_ready_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d   = redirect_pc;
          drop_d = 1'b1;
        end
        if (imem_rvalid_i) begin
          if (drop_q || redirect_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            buf_d    = imem_rdata_i;
            buf_pc_d = fetch_pc_q + 32'd4;
            state_d  = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect_i) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else begin
          instr_o = buf_q;
          pc_o    = buf_pc_q;
          if (!stall_i) state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

`ifdef IFU_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bubble;

  assign bubble       = ~ifid_hold_o & ((state_q != S_FULL) | redirect_i);
  assign bubble_cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (bubble && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule
